// File: rtl/pwm_multichannel.sv
// pwm_multichannel: N-channel PWM with a shared period counter, clock prescaler
// and edge/centre alignment. Duty, period and prescale are written through a
// valid/ready port into shadow registers that are copied to the active set at
// each period boundary, so a running period is never disturbed by a write.
module pwm_multichannel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8,
    localparam int ADDR_W  = $clog2(CHANNELS + 2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                center_mode,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]    cfg_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    logic [WIDTH-1:0] period_sh_reg;
    logic [WIDTH-1:0] period_act_reg;
    logic [PRE_W-1:0] prescale_sh_reg;
    logic [PRE_W-1:0] prescale_act_reg;
    logic [PRE_W-1:0] pre_cnt_reg;
    logic [PRE_W-1:0] pre_data;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             dir_reg;          // 0 = counting up, 1 = counting down
    logic             dir_next;
    logic             mode_act_reg;     // 0 = edge-aligned, 1 = centre-aligned
    logic             restart_reg;      // set while idle: the first tick after run starts is a boundary
    logic             period_start_reg;
    logic             boundary;
    logic             tick;
    logic             load;

    // The config port never stalls
    assign cfg_ready    = 1'b1;
    assign period_start = period_start_reg;

    // Prescale data: low PRE_W bits of the write word, zero-extended if wider
    generate
        if (PRE_W > WIDTH) begin : g_pre_ext
            assign pre_data = {{(PRE_W - WIDTH){1'b0}}, cfg_data};
        end else begin : g_pre_trunc
            assign pre_data = cfg_data[PRE_W-1:0];
        end
    endgenerate

    assign tick = ena && (pre_cnt_reg == prescale_act_reg);
    assign load = tick && boundary;

    // Next counter value/direction and boundary detection for the current tick
    always_comb begin
        boundary = 1'b0;
        cnt_next = cnt_reg + WIDTH'(1);
        dir_next = dir_reg;
        if (restart_reg || (period_act_reg == '0)) begin
            boundary = 1'b1;
        end else if (!mode_act_reg) begin
            boundary = (cnt_reg == period_act_reg);
        end else if (dir_reg) begin
            boundary = (cnt_reg == WIDTH'(1));
        end else begin
            // period==1 in centre mode: the turn-around at the top already lands on 0
            boundary = (cnt_reg == period_act_reg) && (period_act_reg == WIDTH'(1));
        end
        if (boundary) begin
            cnt_next = '0;
            dir_next = 1'b0;
        end else if (mode_act_reg) begin
            if (dir_reg) begin
                cnt_next = cnt_reg - WIDTH'(1);
            end else if (cnt_reg == period_act_reg) begin
                cnt_next = period_act_reg - WIDTH'(1);
                dir_next = 1'b1;
            end
        end
    end

    // Shadow period/prescale registers, written from the config port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh_reg   <= '1;
            prescale_sh_reg <= '0;
        end else if (cfg_valid && cfg_ready) begin
            if (cfg_addr == ADDR_W'(CHANNELS)) begin
                period_sh_reg <= cfg_data;
            end else if (cfg_addr == ADDR_W'(CHANNELS + 1)) begin
                prescale_sh_reg <= pre_data;
            end
        end
    end

    // Active period/prescale/mode, copied from the shadow set on a boundary tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_act_reg   <= '1;
            prescale_act_reg <= '0;
            mode_act_reg     <= 1'b0;
        end else if (load) begin
            period_act_reg   <= period_sh_reg;
            prescale_act_reg <= prescale_sh_reg;
            mode_act_reg     <= center_mode;
        end
    end

    // Prescaler, period counter and boundary pulse; all cleared while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg      <= '0;
            cnt_reg          <= '0;
            dir_reg          <= 1'b0;
            restart_reg      <= 1'b1;
            period_start_reg <= 1'b0;
        end else if (!ena) begin
            pre_cnt_reg      <= '0;
            cnt_reg          <= '0;
            dir_reg          <= 1'b0;
            restart_reg      <= 1'b1;
            period_start_reg <= 1'b0;
        end else begin
            pre_cnt_reg      <= tick ? '0 : pre_cnt_reg + PRE_W'(1);
            period_start_reg <= load;
            if (tick) begin
                cnt_reg <= cnt_next;
                dir_reg <= dir_next;
            end
            if (load) begin
                restart_reg <= 1'b0;
            end
        end
    end

    // Per-channel shadow duty, active duty and registered comparator output
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] duty_sh_reg;
            logic [WIDTH-1:0] duty_act_reg;
            logic             pwm_reg;

            // Shadow duty write, then copy to active on a boundary tick
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_sh_reg  <= '0;
                    duty_act_reg <= '0;
                end else begin
                    if (load) begin
                        duty_act_reg <= duty_sh_reg;
                    end
                    if (cfg_valid && cfg_ready && (cfg_addr == ADDR_W'(gi))) begin
                        duty_sh_reg <= cfg_data;
                    end
                end
            end

            // Output high while the pre-update count is below the active duty
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pwm_reg <= 1'b0;
                end else if (!ena) begin
                    pwm_reg <= 1'b0;
                end else begin
                    pwm_reg <= (cnt_reg < duty_act_reg) && (period_act_reg != '0);
                end
            end

            assign pwm_out[gi] = pwm_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multichannel.sv
// Testbench for pwm_multichannel: a period-position model checked every cycle,
// plus directed scenarios with hand-computed duty/period counts.
module tb_pwm_multichannel;
    localparam int W  = 8;
    localparam int C  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena = 1'b0;
    logic          center_mode = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_ready;
    logic [C-1:0]  pwm_out;
    logic          period_start;

    always #5 clk = ~clk;

    pwm_multichannel #(.WIDTH(W), .CHANNELS(C), .PRE_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .center_mode  (center_mode),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks position p within the current period (ticks since the boundary);
    // the count is derived from p: edge = p, centre = triangle folded at period.
    int           m_sh_duty [C];
    int           m_duty    [C];
    int           m_sh_per  = 255;
    int           m_per     = 255;
    int           m_sh_pre  = 0;
    int           m_pre     = 0;
    bit           m_mode    = 1'b0;
    int           m_q       = 0;
    int           m_p       = 0;
    bit           m_restart = 1'b1;
    logic [C-1:0] exp_pwm   = '0;
    logic         exp_ps    = 1'b0;

    initial begin
        for (int i = 0; i < C; i++) begin
            m_sh_duty[i] = 0;
            m_duty[i]    = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < C; i++) begin
                    m_sh_duty[i] = 0;
                    m_duty[i]    = 0;
                end
                m_sh_per = 255; m_per = 255; m_sh_pre = 0; m_pre = 0;
                m_mode = 1'b0; m_q = 0; m_p = 0; m_restart = 1'b1;
                exp_pwm = '0; exp_ps = 1'b0;
            end else begin
                int cnt, len, a;
                bit tk, bnd;
                if (m_per == 0)   cnt = 0;
                else if (!m_mode) cnt = m_p;
                else              cnt = (m_p <= m_per) ? m_p : 2 * m_per - m_p;
                if (m_per == 0)   len = 1;
                else if (m_mode)  len = 2 * m_per;
                else              len = m_per + 1;
                if (!ena) begin
                    exp_pwm = '0; exp_ps = 1'b0;
                    m_q = 0; m_p = 0; m_restart = 1'b1;
                end else begin
                    tk  = (m_q == m_pre);
                    bnd = tk && (m_restart || (m_p == len - 1));
                    for (int i = 0; i < C; i++)
                        exp_pwm[i] = (m_per != 0) && (cnt < m_duty[i]);
                    exp_ps = bnd;
                    m_q = tk ? 0 : m_q + 1;
                    if (tk) m_p = bnd ? 0 : m_p + 1;
                    if (bnd) begin
                        for (int i = 0; i < C; i++) m_duty[i] = m_sh_duty[i];
                        m_per = m_sh_per; m_pre = m_sh_pre;
                        m_mode = center_mode; m_restart = 1'b0;
                    end
                end
                if (cfg_valid) begin
                    a = int'(cfg_addr);
                    if (a < C)          m_sh_duty[a] = int'(cfg_data);
                    else if (a == C)    m_sh_per     = int'(cfg_data);
                    else if (a == C + 1) m_sh_pre    = int'(cfg_data);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_pwm_out", int'(pwm_out), int'(exp_pwm));
            chk("cyc_period_start", int'(period_start), int'(exp_ps));
            chk("cyc_cfg_ready", int'(cfg_ready), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    int hi_cnt [C];
    int ps_cnt;

    task automatic write_cfg(input int a, input int d);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = a[AW-1:0];
        cfg_data  = d[W-1:0];
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic cycles_to_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 1000);
    endtask

    task automatic wait_ps(input string name);
        int n;
        cycles_to_ps(n);
        if (n >= 1000) chk({name, "_timeout"}, int'(period_start), 1);
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < C; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < C; i++) hi_cnt[i] += int'(pwm_out[i]);
            ps_cnt += int'(period_start);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_pwm_out", int'(pwm_out), 0);
        chk("reset_period_start", int'(period_start), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge mode, period 9, duty0 3, no prescale
        write_cfg(4, 9);
        write_cfg(0, 3);
        ena = 1'b1;
        wait_ps("edge_start");
        measure(10);
        chk("edge_duty0_high", hi_cnt[0], 3);
        chk("edge_ps_per10", ps_cnt, 1);

        // Mid-period write 3->7: current period keeps 3
        wait_ps("midwrite_align");
        for (int i = 0; i < C; i++) hi_cnt[i] = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi_cnt[0] += int'(pwm_out[0]);
            if (k == 4) begin
                cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd7;
            end
            if (k == 5) cfg_valid = 1'b0;
        end
        chk("midwrite_current", hi_cnt[0], 3);
        measure(10);
        chk("midwrite_next", hi_cnt[0], 7);

        // Write on the boundary cycle: applies one period later
        repeat (9) @(negedge clk);
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("bnd_write_aligned", int'(period_start), 1);
        measure(10);
        chk("bnd_write_old", hi_cnt[0], 7);
        measure(10);
        chk("bnd_write_new", hi_cnt[0], 2);

        // Centre mode, period 4, duty1 2: cnt 0,1,2,3,4,3,2,1
        center_mode = 1'b1;
        write_cfg(1, 2);
        write_cfg(4, 4);
        wait_ps("centre_start");
        measure(8);
        chk("centre_duty1_high", hi_cnt[1], 3);
        chk("centre_ps_per8", ps_cnt, 1);

        // Prescale 2, period 3, edge: 12 clk per period
        center_mode = 1'b0;
        write_cfg(5, 2);
        write_cfg(4, 3);
        wait_ps("presc_start");
        cycles_to_ps(n);
        chk("presc_period_clks", n, 12);

        // Period 0: every tick a boundary, all outputs low
        write_cfg(5, 0);
        write_cfg(4, 0);
        wait_ps("per0_start");
        measure(10);
        chk("per0_ch0_high", hi_cnt[0], 0);
        chk("per0_ch1_high", hi_cnt[1], 0);
        chk("per0_ps_every_clk", ps_cnt, 10);

        // duty 255 > period 9: constant high; duty 0: constant low
        write_cfg(2, 255);
        write_cfg(4, 9);
        wait_ps("duty255_start");
        measure(10);
        chk("duty255_high", hi_cnt[2], 10);
        chk("duty0_high", hi_cnt[3], 0);
        chk("duty2_high", hi_cnt[0], 2);

        // ena drop mid-period, write while idle, restart loads shadow
        repeat (4) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("idle_pwm_out", int'(pwm_out), 0);
        chk("idle_period_start", int'(period_start), 0);
        write_cfg(0, 5);
        ena = 1'b1;
        cycles_to_ps(n);
        chk("restart_ps_latency", n, 1);
        measure(10);
        chk("restart_duty0_high", hi_cnt[0], 5);

        // Async reset mid-run
        @(negedge clk);
        chk("pre_reset_ch2_high", int'(pwm_out[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm_out", int'(pwm_out), 0);
        chk("async_period_start", int'(period_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles_to_ps(n);
        chk("post_reset_first_ps", n, 1);
        cycles_to_ps(n);
        chk("post_reset_period_clks", n, 256);
        measure(20);
        chk("post_reset_duty2", hi_cnt[2], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
